seven_segment_scan_mux: RTL and testbench

//  Downstream stage of the per-digit decimal-to-7-segment decoders in the Pong score display.

---
 rtl/seven_segment_scan_mux_pkg.sv | 18 +
 rtl/seven_segment_scan_mux_prescaler.sv | 38 +++
 rtl/seven_segment_scan_mux.sv | 129 ++++++++++++
 tb/tb_seven_segment_scan_mux.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_scan_mux_pkg.sv
// Shared constants, scan FSM state type and pin-polarity helper for the
// seven-segment scan multiplexer.
package seven_seg_pkg;

  localparam logic [6:0] ZERO_PATTERN = 7'b1111110;
  localparam logic [6:0] SEG_OFF      = 7'b0000000;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Converts an active-high value into its pin-level form.
  function automatic logic [7:0] apply_pol(input logic [7:0] value, input logic active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/seven_segment_scan_mux_prescaler.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1 and flags the end of the slot
// and the end of the leading guard interval.
module scan_prescaler #(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_slot_end,
  output logic o_guard_done
);

  localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_slot_end;

  assign w_slot_end = (r_cnt == LAST_CNT);
  assign o_slot_end = w_slot_end;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_cnt <= '0;
    else if (w_slot_end) r_cnt <= '0;
    else                 r_cnt <= r_cnt + CNT_W'(1);
  end

  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign o_guard_done = 1'b1;
    end else begin : g_guard
      localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
      assign o_guard_done = (r_cnt == GUARD_LAST);
    end
  endgenerate

endmodule

// File: rtl/seven_segment_scan_mux.sv
// Time-multiplexes NUM_DIGITS decoded 7-segment patterns onto one segment bus with
// guarded anode switching. Optional: SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seven_segment_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7*NUM_DIGITS-1:0] i_segments,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_enable,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_anode,
  output logic                    o_frame_tick
);

  localparam int                    IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_POL8 = apply_pol(8'h00, SEG_ACTIVE_LOW);
  localparam logic [7:0]            AN_POL8  = apply_pol(8'h00, AN_ACTIVE_LOW);
  localparam logic [6:0]            SEG_XOR  = SEG_POL8[6:0];
  localparam logic                  DP_XOR   = SEG_POL8[7];
  localparam logic [NUM_DIGITS-1:0] AN_XOR   = AN_POL8[NUM_DIGITS-1:0];

  logic [IDX_W-1:0]      r_idx, w_idx_next;
  scan_state_t           r_state, w_state_next;
  logic                  w_slot_end, w_guard_done, w_idx_legal, w_wrap;
  logic [6:0]            w_seg_sel;
  logic                  w_dp_sel;
  logic [NUM_DIGITS-1:0] w_onehot, w_blank;
  logic [6:0]            r_seg;
  logic                  r_dp, r_frame_tick;
  logic [NUM_DIGITS-1:0] r_anode;

  scan_prescaler #(
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_prescaler (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_slot_end   (w_slot_end),
    .o_guard_done (w_guard_done)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // A digit is blank only while it and every higher digit is a bare zero; digit 0 never is.
  always_comb begin
    logic w_above_zero;
    w_blank      = '0;
    w_above_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_above_zero = w_above_zero && (i_segments[7*k +: 7] == ZERO_PATTERN) && !i_dp[k];
      w_blank[k]   = w_above_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_seg_sel   = SEG_OFF;
    w_dp_sel    = 1'b0;
    w_onehot    = '0;
    w_idx_legal = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_idx_legal = 1'b1;
        w_onehot[k] = 1'b1;
        w_seg_sel   = w_blank[k] ? SEG_OFF : i_segments[7*k +: 7];
        w_dp_sel    = i_dp[k] && !w_blank[k];
      end
    end
  end

  assign w_wrap = w_idx_legal && w_slot_end && (r_idx == LAST_IDX);

  always_comb begin
    w_idx_next = r_idx;
    if (!w_idx_legal)    w_idx_next = '0;
    else if (w_slot_end) w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
  end

  // With no guard interval the FSM stays in DRIVE and anodes hand over edge to edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      GUARD:   if (w_guard_done) w_state_next = DRIVE;
      DRIVE:   if (w_slot_end && (GUARD_CYCLES != 0)) w_state_next = GUARD;
      default: w_state_next = GUARD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= GUARD;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg        <= SEG_OFF ^ SEG_XOR;
      r_dp         <= DP_XOR;
      r_anode      <= AN_XOR;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg_sel ^ SEG_XOR;
      r_dp         <= w_dp_sel ^ DP_XOR;
      r_anode      <= ((i_enable && (r_state == DRIVE)) ? w_onehot : '0) ^ AN_XOR;
      r_frame_tick <= w_wrap;
    end
  end

  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_anode      = r_anode;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_segment_scan_mux.sv
// Bench for seven_segment_scan_mux: a guarded 8-clock-slot instance and a
// guardless 2-clock-slot instance, checked against a time-based scan model.
module tb_seven_segment_scan_mux;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b1;
  logic [27:0] segments = '0;
  logic [3:0]  dp = '0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, tick_a, tick_b;
  logic [3:0] an_a, an_b;

  always #5 clk = ~clk;

  seven_segment_scan_mux #(
    .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .GUARD_CYCLES(GUARD),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_segments(segments), .i_dp(dp), .i_enable(enable),
    .o_seg(seg_a), .o_dp(dp_a), .o_anode(an_a), .o_frame_tick(tick_a)
  );

  seven_segment_scan_mux #(
    .NUM_DIGITS(ND), .REFRESH_DIV(2), .GUARD_CYCLES(0),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_dut_fast (
    .i_clk(clk), .i_rst_n(rst_n), .i_segments(segments), .i_dp(dp), .i_enable(enable),
    .o_seg(seg_b), .o_dp(dp_b), .o_anode(an_b), .o_frame_tick(tick_b)
  );

  typedef struct {
    logic [27:0] segs;
    logic [3:0]  dp;
    int          cycles;
    string       name;
  } vec_t;

  typedef struct {
    logic [3:0] an_a;
    logic [6:0] seg_a;
    logic       dp_a;
    logic       tick_a;
    logic [3:0] an_b;
    logic [6:0] seg_b;
    logic       dp_b;
    logic       tick_b;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  int   ref_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, ref_t);
    end
  endtask

  function automatic logic [6:0] digit_pat(input int k);
    return segments[7*k +: 7];
  endfunction

  // Pattern digit k should show, active-high.
  function automatic logic [6:0] shown(input int k);
    logic [6:0] p;
    bit         all_zero;
    p = digit_pat(k);
    all_zero = (k > 0);
    for (int j = k; j < ND; j++)
      if (digit_pat(j) != 7'b1111110 || dp[j]) all_zero = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (all_zero) p = 7'h00;
`endif
    return p;
  endfunction

  // Predict both DUTs after the coming edge from edges-since-reset, then compare.
  task automatic step();
    exp_t       e;
    int         ia, ib;
    logic [3:0] oha, ohb;
    ia = (ref_t / DIV) % ND;
    ib = (ref_t / 2) % ND;
    oha = '0; oha[ia] = 1'b1;
    ohb = '0; ohb[ib] = 1'b1;
    e.an_a   = (enable && (ref_t % DIV) >= GUARD) ? ~oha : 4'hF;
    e.seg_a  = ~shown(ia);
    e.dp_a   = ~dp[ia];
    e.tick_a = ((ref_t % (DIV*ND)) == DIV*ND - 1);
    e.an_b   = (enable && ref_t >= 1) ? ~ohb : 4'hF;
    e.seg_b  = ~shown(ib);
    e.dp_b   = ~dp[ib];
    e.tick_b = ((ref_t % (2*ND)) == 2*ND - 1);
    exp_q.push_back(e);
    @(posedge clk);
    ref_t++;
    @(negedge clk);
    e = exp_q.pop_front();
    check("anode_a", 32'(an_a), 32'(e.an_a));
    check("seg_a", 32'(seg_a), 32'(e.seg_a));
    check("dp_a", 32'(dp_a), 32'(e.dp_a));
    check("tick_a", 32'(tick_a), 32'(e.tick_a));
    check("anode_b", 32'(an_b), 32'(e.an_b));
    check("seg_b", 32'(seg_b), 32'(e.seg_b));
    check("dp_b", 32'(dp_b), 32'(e.dp_b));
    check("tick_b", 32'(tick_b), 32'(e.tick_b));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_anode_a"}, 32'(an_a), 32'hF);
    check({tag, "_seg_a"}, 32'(seg_a), 32'h7F);
    check({tag, "_dp_a"}, 32'(dp_a), 32'h1);
    check({tag, "_tick_a"}, 32'(tick_a), 32'h0);
    check({tag, "_anode_b"}, 32'(an_b), 32'hF);
    check({tag, "_tick_b"}, 32'(tick_b), 32'h0);
  endtask

  // No two anodes may ever be on together, on either instance.
  always @(negedge clk) begin
    checks++;
    if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
      failures++;
      $display("FAIL anode_onehot: got a=%b b=%b expected at most one low bit", an_a, an_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_tick_a, n_tick_b, n_d0;
    logic [6:0] new_pat;

    vecs[0] = '{segs: {7'h33, 7'h79, 7'h6D, 7'h30}, dp: 4'b0000, cycles: 64, name: "digits_1234"};
    vecs[1] = '{segs: {7'h5B, 7'h7E, 7'h70, 7'h6D}, dp: 4'b0101, cycles: 32, name: "dp_mix"};
    vecs[2] = '{segs: {7'h7E, 7'h7E, 7'h7E, 7'h70}, dp: 4'b0000, cycles: 32, name: "lead0_0007"};
    vecs[3] = '{segs: {7'h7E, 7'h5B, 7'h7E, 7'h7E}, dp: 4'b0000, cycles: 32, name: "lead0_0500"};
    vecs[4] = '{segs: {7'h7E, 7'h7E, 7'h7E, 7'h7E}, dp: 4'b0000, cycles: 32, name: "all_zero"};
    vecs[5] = '{segs: {7'h7E, 7'h7E, 7'h7E, 7'h7E}, dp: 4'b0100, cycles: 32, name: "zero_dp"};

    // Reset and first-anode latency
    segments = vecs[0].segs;
    dp = vecs[0].dp;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_t = 0;
    step();
    step();
    check("latency_clk2_anode", 32'(an_a), 32'hF);
    step();
    check("latency_clk3_anode", 32'(an_a), 32'hE);

    // Table-driven scan vectors
    foreach (vecs[v]) begin
      segments = vecs[v].segs;
      dp = vecs[v].dp;
      n_tick_a = 0; n_tick_b = 0; n_d0 = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        step();
        if (tick_a) n_tick_a++;
        if (tick_b) n_tick_b++;
        if (an_a == 4'b1110) n_d0++;
      end
      if (v == 0) begin
        check("frame_ticks_a_64clk", 32'(n_tick_a), 32'd2);
        check("frame_ticks_b_64clk", 32'(n_tick_b), 32'd8);
        check("digit0_on_64clk", 32'(n_d0), 32'd12);
      end
    end

    // Input change in the middle of digit 0's drive window
    segments = vecs[0].segs;
    dp = '0;
    for (int c = 0; c < 40 && (ref_t % (DIV*ND)) != 4; c++) step();
    check("mid_drive_phase", 32'(ref_t % (DIV*ND)), 32'd4);
    check("mid_drive_seg_before", 32'(seg_a), 32'(~7'h30 & 7'h7F));
    new_pat = 7'h5B;
    segments[6:0] = new_pat;
    step();
    check("mid_drive_seg_after", 32'(seg_a), 32'(~new_pat & 7'h7F));
    check("mid_drive_anode", 32'(an_a), 32'hE);
    repeat (8) step();

    // Enable pulsed low for 5 clocks inside a drive window
    for (int c = 0; c < 10 && (ref_t % DIV) != 2; c++) step();
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("enable_low_anode", 32'(an_a), 32'hF);
    end
    enable = 1'b1;
    repeat (40) step();

    // Reset asserted mid-slot blanks at once; scan restarts from digit 0
    for (int c = 0; c < 10 && (ref_t % DIV) != 5; c++) step();
    check("pre_reset_anode_on", 32'($countones(~an_a)), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midslot_reset");
    repeat (2) @(negedge clk);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    ref_t = 0;
    repeat (2) step();
    step();
    check("rerelease_latency_anode", 32'(an_a), 32'hE);
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
